// File: rtl/foo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : foo_pkg
// Purpose  : Shared lane type and width for the foo serializer.
// Revision : 1.0 - initial release
// ============================================================================
package foo_pkg;

   localparam int FOO_W = 8;

   typedef struct packed {
      logic [3:0] adr;
      logic [3:0] val;
   } foo_s;

endpackage : foo_pkg
`default_nettype wire

// File: rtl/foo_lane_pick.sv
`default_nettype none
// ============================================================================
// Module   : foo_lane_pick
// Purpose  : Finds the lowest set lane in a mask, its one-hot, and whether
//            it is the only lane left.
// Revision : 1.0 - initial release
// ============================================================================
module foo_lane_pick #(
   parameter int NLANES = 4,
   parameter int IDX_W  = 2
) (
   input  logic [NLANES-1:0] mask,
   output logic [IDX_W-1:0]  idx,
   output logic [NLANES-1:0] clr,
   output logic              only_one
);

   logic [NLANES-1:0] w_mask_m1;

   assign w_mask_m1 = mask - NLANES'(1);
   // x & ~(x-1) isolates the lowest set bit
   assign clr       = mask & ~w_mask_m1;
   assign only_one  = (mask != '0) && ((mask & w_mask_m1) == '0);

   always_comb begin
      idx = '0;
      for (int k = NLANES - 1; k >= 0; k--) begin
         if (mask[k]) idx = IDX_W'(k);
      end
   end

endmodule : foo_lane_pick
`default_nettype wire

// File: rtl/foo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : foo_serializer
// Purpose  : Accepts a word of NLANES packed lanes plus a mask and emits the
//            enabled lanes one per handshake, lowest index first.
// Revision : 1.0 - initial release
// ============================================================================
module foo_serializer
   import foo_pkg::*;
#(
   parameter int NLANES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  foo_s [NLANES-1:0]       in_data,
   input  logic [NLANES-1:0]       in_mask,
   output logic                    out_valid,
   input  logic                    out_ready,
   output foo_s                    out_data,
   output logic                    out_last,
   output logic [7:0]              out_count
);

   localparam int         c_idx_w = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam logic [0:0] c_idle  = 1'b0;
   localparam logic [0:0] c_emit  = 1'b1;

   logic [0:0]         r_state;
   logic [NLANES-1:0]  r_mask;
   foo_s [NLANES-1:0]  r_data;
   logic [7:0]         r_count;

   logic [c_idx_w-1:0] w_idx;
   logic [NLANES-1:0]  w_clr;
   logic               w_only;
   logic               w_in_xfer;
   logic               w_out_xfer;

   foo_lane_pick #(
      .NLANES (NLANES),
      .IDX_W  (c_idx_w)
   ) u_pick (
      .mask     (r_mask),
      .idx      (w_idx),
      .clr      (w_clr),
      .only_one (w_only)
   );

   assign out_valid  = (r_state == c_emit);
   assign out_last   = out_valid && w_only;
   assign out_data   = r_data[w_idx];
   assign out_count  = r_count;
   // Gated by rst so upstream sees "not ready" for the whole reset window
   assign in_ready   = !rst && (!out_valid || (out_ready && out_last));
   assign w_in_xfer  = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= c_idle;
         r_mask  <= '0;
         r_data  <= '0;
         r_count <= '0;
      end else begin
         if (w_out_xfer) begin
            r_count <= r_count + 8'd1;
            r_mask  <= r_mask & ~w_clr;
         end
         // A new word can only arrive alongside the final lane, so it overrides the clear
         if (w_in_xfer) begin
            r_mask <= in_mask;
            if (|in_mask) begin
               r_data  <= in_data;
               r_state <= c_emit;
            end else begin
               r_state <= c_idle;
            end
         end else if (w_out_xfer && out_last) begin
            r_state <= c_idle;
         end
      end
   end

endmodule : foo_serializer
`default_nettype wire

// File: tb/tb_foo_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_foo_serializer
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            random traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_foo_serializer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [3:0]  in_mask;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_last;
   logic [7:0]  out_count;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_cnt;

   typedef struct {
      logic        iv;
      logic [3:0]  im;
      logic [31:0] id;
      logic        ordy;
      logic        er;
      logic        ev;
      logic [7:0]  ed;
      logic        el;
      logic [7:0]  ec;
   } vec_t;

   vec_t tbl[11];

   foo_serializer #(.NLANES(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mask   (in_mask),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_count (out_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle driven and checked against the reference queue model
   task automatic cycle(input logic iv, input logic [3:0] im, input logic [31:0] id,
                        input logic ordy);
      logic irdy;
      logic ev;
      in_valid  = iv;
      in_mask   = im;
      in_data   = id;
      out_ready = ordy;
      #2;
      ev   = (exp_q.size() > 0);
      irdy = !ev || (ordy && exp_q.size() == 1);
      chk("in_ready", in_ready, irdy);
      chk("out_valid", out_valid, ev);
      chk("out_last", out_last, ev && exp_q.size() == 1);
      if (ev) chk("out_data", out_data, exp_q[0]);
      chk("out_count", out_count, exp_cnt);
      if (ev && ordy) begin
         void'(exp_q.pop_front());
         exp_cnt++;
      end
      if (iv && irdy) begin
         for (int k = 0; k < 4; k++)
            if (im[k]) exp_q.push_back(id[8*k +: 8]);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] xv;
      logic [7:0] zv;
      logic [3:0] pat;

      tbl[0]  = '{1'b1, 4'hF, 32'h33221100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd0};
      tbl[1]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'd0};
      tbl[2]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd1};
      tbl[3]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 8'd2};
      tbl[4]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'd3};
      tbl[5]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4};
      tbl[6]  = '{1'b1, 4'hA, 32'h33221100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd4};
      tbl[7]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 8'd4};
      tbl[8]  = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b1, 8'h33, 1'b1, 8'd5};
      tbl[9]  = '{1'b1, 4'h0, 32'h33221100, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd6};
      tbl[10] = '{1'b0, 4'h0, 32'h0,        1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'd6};

      rst = 1'b1; in_valid = 1'b0; in_mask = '0; in_data = '0; out_ready = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_count", out_count, 8'h00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         in_valid = tbl[i].iv; in_mask = tbl[i].im; in_data = tbl[i].id;
         out_ready = tbl[i].ordy;
         #2;
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].er);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].ev);
         chk($sformatf("tbl%0d_out_last", i), out_last, tbl[i].el);
         if (tbl[i].ev) chk($sformatf("tbl%0d_out_data", i), out_data, tbl[i].ed);
         chk($sformatf("tbl%0d_out_count", i), out_count, tbl[i].ec);
         @(posedge clk);
         #1;
      end
      exp_q.delete();
      exp_cnt = 8'd6;

      // Back-to-back words with in_valid held high
      cycle(1'b1, 4'hF, 32'h44332211, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b1, 4'hF, 32'h88776655, 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'h0, 32'h0, 1'b1);

      // Stall pattern 1,0,0,1 while a word drains
      pat = 4'b1001;
      cycle(1'b1, 4'hF, 32'hD4C3B2A1, 1'b1);
      for (int i = 0; i < 14; i++) cycle(1'b0, 4'h0, 32'h0, pat[i % 4]);

      // Unknown and high-impedance bits pass through untouched
      xv = 8'hx3;
      zv = 8'hz1;
      cycle(1'b1, 4'h3, {16'h0, zv, xv}, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b0, 4'h0, 32'h0, 1'b1);

      // Asynchronous reset between edges after two beats of a 4-lane word
      cycle(1'b1, 4'hF, 32'h3C2B1A09, 1'b1);
      cycle(1'b0, 4'h0, 32'h0, 1'b1);
      cycle(1'b0, 4'h0, 32'h0, 1'b1);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_out_valid", out_valid, 1'b0);
      chk("arst_out_count", out_count, 8'h00);
      chk("arst_out_data", out_data, 8'h00);
      chk("arst_out_last", out_last, 1'b0);
      chk("arst_in_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = 8'd0;
      cycle(1'b1, 4'hF, 32'h77665544, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 32'h0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++)
         cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom,
               1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 32'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_foo_serializer
`default_nettype wire
